bus_dma_master: RTL

- Bus initiator for the z8086 SoC memory/I-O bus. It drives the same request signals the CPU drives (addr, dout, rd, wr, io, word) and completes on the shared ready/din responder handshake.
- Copies a block of bytes or words from a source address to a destination, which may be memory or an I/O port.
- Programmed through an I/O-style settings interface (io_addr/io_rd/io_wr/io_din/io_dout), decoded by the SoC top like the video register window.
- Takes the bus from the CPU via a bus_req/bus_gnt pair.

---
 rtl/bus_dma_master.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/bus_dma_master.sv
// bus_dma_master
// Block-copy bus initiator for the z8086 SoC memory/I-O bus. It requests the
// bus from the CPU through bus_req/bus_gnt. Once granted, it copies COUNT bytes
// from SRC to DST, one unit at a time: a read access followed by a write
// access. A unit is a byte, or a word in word mode. Every access completes on
// the shared ready/din handshake. The block is programmed through a small
// I/O register window.
//
// Ports
//   clk, reset        clk50 domain clock, asynchronous active-high reset
//   io_addr/io_rd/io_wr/io_din/io_dout
//                     register window (io_dout is combinational from io_addr)
//   bus_req, bus_gnt  arbitration with the CPU
//   addr, dout, rd, wr, io, word
//                     bus request signals, the same ones the CPU drives
//   din, ready        responder read data and completion pulse
//   irq               done level, cleared by a STATUS write with bit1 set
//
// Register map (io_addr)
//   0 SRC[15:0]   1 SRC[19:16]   2 DST[15:0]   3 DST[19:16]   4 COUNT (bytes)
//   5 CTRL: bit1 word mode, bit2 dst_fixed, bit3 dst_io, bit4 src_io
//   6 CMD write: bit0 start, bit1 clear done, bit7 abort
//     STATUS read: bit0 busy, bit1 done, bit2 aborted
//   7 reads 0
module bus_dma_master #(
  parameter int ADDR_W = 20,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        io_addr,
  input  logic              io_rd,
  input  logic              io_wr,
  input  logic [15:0]       io_din,
  output logic [15:0]       io_dout,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       dout,
  output logic              rd,
  output logic              wr,
  output logic              io,
  output logic              word,
  input  logic [15:0]       din,
  input  logic              ready,
  output logic              irq
);

  typedef enum logic [2:0] {IDLE, ARB, RD, WR, STEP, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              word_mode;
  logic              dst_fixed;
  logic              dst_io;
  logic              src_io;
  logic              done;
  logic              aborted;
  logic              abort_pend;
  logic              rd_req;
  logic              wr_req;
  logic [15:0]       data_q;

  // Reads have no side effects, so the read strobe is not needed.
  logic unused_io_rd;
  assign unused_io_rd = io_rd;

  // Command decode. busy covers every non-IDLE state. Abort is only
  // meaningful while a copy is actually in flight.
  logic busy;
  logic in_transfer;
  logic cmd_wr;
  logic start_cmd;
  logic abort_cmd;
  logic abort_req;

  assign busy        = (state != IDLE);
  assign in_transfer = (state == ARB) || (state == RD) || (state == WR) || (state == STEP);
  assign cmd_wr      = io_wr && (io_addr == 3'd6);
  assign start_cmd   = cmd_wr && io_din[0] && !busy;
  assign abort_cmd   = cmd_wr && io_din[7] && in_transfer;
  assign abort_req   = abort_pend || abort_cmd;

  // Unit sizing. Word units are used only while at least two bytes remain,
  // so an odd count always ends with a byte unit. The step comes from the
  // registered word flag of the unit that just completed.
  logic              unit_is_word;
  logic [1:0]        step;
  logic [ADDR_W-1:0] src_next;
  logic [ADDR_W-1:0] dst_next;
  logic [CNT_W-1:0]  cnt_next;

  assign unit_is_word = word_mode && (count_reg >= CNT_W'(2));
  assign step         = word ? 2'd2 : 2'd1;
  assign src_next     = src_reg + ADDR_W'(step);
  assign dst_next     = dst_reg + ADDR_W'(step);
  assign cnt_next     = count_reg - CNT_W'(step);

  // The request flags are masked in the ready cycle, so the responder never
  // sees a request that it has already completed.
  assign rd = rd_req & ~ready;
  assign wr = wr_req & ~ready;

  // Zero-extend the addresses to 32 bits. The high-half registers can then
  // be sliced the same way for any ADDR_W up to 32.
  logic [31:0] src_ext;
  logic [31:0] dst_ext;
  assign src_ext = 32'(src_reg);
  assign dst_ext = 32'(dst_reg);

  // Register read mux. SRC, DST and COUNT show live progress.
  always_comb begin
    io_dout = 16'h0000;
    case (io_addr)
      3'd0: io_dout = src_ext[15:0];
      3'd1: io_dout = src_ext[31:16];
      3'd2: io_dout = dst_ext[15:0];
      3'd3: io_dout = dst_ext[31:16];
      3'd4: io_dout = 16'(count_reg);
      3'd5: io_dout = {11'b0, src_io, dst_io, dst_fixed, word_mode, 1'b0};
      3'd6: io_dout = {13'b0, aborted, done, busy};
      default: io_dout = 16'h0000;
    endcase
  end

  // Register writes, the command register and the transfer FSM.
  // Each bus access has two phases:
  //   - The issue cycle. The request flag is still low. Address, data, io
  //     and word are loaded together with the flag.
  //   - The wait phase. It lasts until ready.
  // This gives at least one idle bus cycle between accesses. It also keeps
  // the bus fields stable for the whole request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      src_reg    <= '0;
      dst_reg    <= '0;
      count_reg  <= '0;
      word_mode  <= 1'b0;
      dst_fixed  <= 1'b0;
      dst_io     <= 1'b0;
      src_io     <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      abort_pend <= 1'b0;
      rd_req     <= 1'b0;
      wr_req     <= 1'b0;
      data_q     <= 16'h0000;
      bus_req    <= 1'b0;
      addr       <= '0;
      dout       <= 16'h0000;
      io         <= 1'b0;
      word       <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (io_wr && !busy) begin
        case (io_addr)
          3'd0: src_reg   <= ADDR_W'({src_ext[31:16], io_din});
          3'd1: src_reg   <= ADDR_W'({io_din, src_ext[15:0]});
          3'd2: dst_reg   <= ADDR_W'({dst_ext[31:16], io_din});
          3'd3: dst_reg   <= ADDR_W'({io_din, dst_ext[15:0]});
          3'd4: count_reg <= CNT_W'(io_din);
          3'd5: begin
            word_mode <= io_din[1];
            dst_fixed <= io_din[2];
            dst_io    <= io_din[3];
            src_io    <= io_din[4];
          end
          default: ;
        endcase
      end

      // Clear-done is honoured in any state. It comes before the FSM so
      // that a completion in the same cycle still sets done.
      if (cmd_wr && io_din[1]) begin
        done <= 1'b0;
        irq  <= 1'b0;
      end

      // An abort arriving mid-access is held until the access boundary.
      if (abort_cmd) abort_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (start_cmd) begin
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            if (count_reg == '0) begin
              state <= DONE;
            end else begin
              bus_req <= 1'b1;
              state   <= ARB;
            end
          end
        end

        ARB: begin
          if (abort_req) begin
            aborted <= 1'b1;
            state   <= DONE;
          end else if (bus_gnt) begin
            state <= RD;
          end
        end

        RD: begin
          if (!rd_req) begin
            if (abort_req) begin
              aborted <= 1'b1;
              state   <= DONE;
            end else if (!bus_gnt) begin
              state <= ARB;
            end else begin
              addr   <= src_reg;
              io     <= src_io;
              word   <= unit_is_word;
              rd_req <= 1'b1;
            end
          end else if (ready) begin
            rd_req <= 1'b0;
            data_q <= word ? din : {8'h00, din[7:0]};
            if (abort_req) begin
              aborted <= 1'b1;
              state   <= DONE;
            end else begin
              state <= WR;
            end
          end
        end

        // The unit's read is done. Its write always goes out, but only
        // while granted. The word flag is kept from the read.
        WR: begin
          if (!wr_req) begin
            if (bus_gnt) begin
              addr   <= dst_reg;
              io     <= dst_io;
              dout   <= data_q;
              wr_req <= 1'b1;
            end
          end else if (ready) begin
            wr_req <= 1'b0;
            state  <= STEP;
          end
        end

        STEP: begin
          count_reg <= cnt_next;
          src_reg   <= src_next;
          if (!dst_fixed) dst_reg <= dst_next;
          if (cnt_next == '0) begin
            state <= DONE;
          end else if (abort_req) begin
            aborted <= 1'b1;
            state   <= DONE;
          end else if (!bus_gnt) begin
            state <= ARB;
          end else begin
            state <= RD;
          end
        end

        DONE: begin
          bus_req    <= 1'b0;
          done       <= 1'b1;
          irq        <= 1'b1;
          abort_pend <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
